reg_ctrl_seq: RTL and testbench

Command-side sequencer for the general-purpose `register` control interface (cl/ld/inc/dec/sr/sl). It accepts one multi-cycle register operation per valid/ready handshake, for example "shift right 5 times with fill 1". It then drives exactly one control strobe per cycle for the requested repeat count and pulses `done` when finished. It sits between the CPU control unit and any datapath register, such as the accumulator or shift register, and replaces hand-coded strobe sequences in the control FSM.

---
 rtl/reg_ctrl_pkg.sv | 53 +++++
 rtl/reg_ctrl_shadow.sv | 47 ++++
 rtl/reg_ctrl_seq.sv | 173 +++++++++++++++++
 tb/tb_reg_ctrl_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared op codes, FSM encoding and strobe payload for the register control sequencer.
package reg_ctrl_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
    localparam logic [OP_W-1:0] OP_CLR  = 3'd1;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd2;
    localparam logic [OP_W-1:0] OP_INC  = 3'd3;
    localparam logic [OP_W-1:0] OP_DEC  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic cl;
        logic ld;
        logic inc;
        logic dec;
        logic sr;
        logic sl;
    } strobe_t;

    // One-hot strobe for an op; NOP and reserved codes map to no strobe.
    function automatic strobe_t op_strobe(input logic [OP_W-1:0] op);
        strobe_t s;
        s = '0;
        case (op)
            OP_CLR:  s.cl  = 1'b1;
            OP_LOAD: s.ld  = 1'b1;
            OP_INC:  s.inc = 1'b1;
            OP_DEC:  s.dec = 1'b1;
            OP_SHR:  s.sr  = 1'b1;
            OP_SHL:  s.sl  = 1'b1;
            default: s     = '0;
        endcase
        return s;
    endfunction

    function automatic logic op_single(input logic [OP_W-1:0] op);
        return (op == OP_CLR) || (op == OP_LOAD);
    endfunction

    function automatic logic op_counted(input logic [OP_W-1:0] op);
        return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/reg_ctrl_shadow.sv
// Predicts the target register value from the strobes this sequencer issues.
module reg_ctrl_shadow
    import reg_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  strobe_t               strb_i,
    input  logic [DATA_WIDTH-1:0] reg_in_i,
    input  logic                  ir_i,
    input  logic                  il_i,
    output logic [DATA_WIDTH-1:0] shadow_o
);

    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] shadow_d;

    // Strobes are one-hot, so priority order only matters for robustness.
    always_comb begin
        shadow_d = shadow_q;
        if (strb_i.cl) begin
            shadow_d = '0;
        end else if (strb_i.ld) begin
            shadow_d = reg_in_i;
        end else if (strb_i.inc) begin
            shadow_d = shadow_q + DATA_WIDTH'(1);
        end else if (strb_i.dec) begin
            shadow_d = shadow_q - DATA_WIDTH'(1);
        end else if (strb_i.sr) begin
            shadow_d = {ir_i, shadow_q[DATA_WIDTH-1:1]};
        end else if (strb_i.sl) begin
            shadow_d = {shadow_q[DATA_WIDTH-2:0], il_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/reg_ctrl_seq.sv
// Register control sequencer: one op per handshake, one strobe per cycle, done pulse.
// Shadow register prediction is built only when REG_CTRL_SEQ_SHADOW_EN is defined.
module reg_ctrl_seq
    import reg_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_W-1:0]       req_op,
    input  logic [CNT_WIDTH-1:0]  req_cnt,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  req_fill,
    output logic                  done,
    output logic                  reg_cl,
    output logic                  reg_ld,
    output logic                  reg_inc,
    output logic                  reg_dec,
    output logic                  reg_sr,
    output logic                  reg_sl,
    output logic [DATA_WIDTH-1:0] reg_in,
    output logic                  reg_ir,
    output logic                  reg_il,
    output logic [DATA_WIDTH-1:0] shadow
);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]       op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fill_q, fill_d;
    strobe_t               strb_q, strb_d;
    logic [DATA_WIDTH-1:0] reg_in_q, reg_in_d;
    logic                  ir_q, ir_d;
    logic                  il_q, il_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;

    logic                  iss;
    logic [OP_W-1:0]       iss_op;
    logic [DATA_WIDTH-1:0] iss_data;
    logic                  iss_fill;

    // cnt_q holds strobes remaining after the one currently on the outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        data_d   = data_q;
        fill_d   = fill_q;
        strb_d   = '0;
        reg_in_d = '0;
        ir_d     = 1'b0;
        il_d     = 1'b0;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        iss      = 1'b0;
        iss_op   = op_q;
        iss_data = data_q;
        iss_fill = fill_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    op_d     = req_op;
                    data_d   = req_data;
                    fill_d   = req_fill;
                    iss_op   = req_op;
                    iss_data = req_data;
                    iss_fill = req_fill;
                    ready_d  = 1'b0;
                    if (op_single(req_op)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        iss     = 1'b1;
                    end else if (op_counted(req_op) && (req_cnt != '0)) begin
                        state_d = ST_RUN;
                        cnt_d   = req_cnt - CNT_WIDTH'(1);
                        iss     = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    iss   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        if (iss) begin
            strb_d   = op_strobe(iss_op);
            reg_in_d = (iss_op == OP_LOAD) ? iss_data : '0;
            ir_d     = (iss_op == OP_SHR) && iss_fill;
            il_d     = (iss_op == OP_SHL) && iss_fill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_NOP;
            data_q   <= '0;
            fill_q   <= 1'b0;
            strb_q   <= '0;
            reg_in_q <= '0;
            ir_q     <= 1'b0;
            il_q     <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            data_q   <= data_d;
            fill_q   <= fill_d;
            strb_q   <= strb_d;
            reg_in_q <= reg_in_d;
            ir_q     <= ir_d;
            il_q     <= il_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign reg_cl    = strb_q.cl;
    assign reg_ld    = strb_q.ld;
    assign reg_inc   = strb_q.inc;
    assign reg_dec   = strb_q.dec;
    assign reg_sr    = strb_q.sr;
    assign reg_sl    = strb_q.sl;
    assign reg_in    = reg_in_q;
    assign reg_ir    = ir_q;
    assign reg_il    = il_q;

`ifdef REG_CTRL_SEQ_SHADOW_EN
    reg_ctrl_shadow #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .strb_i   (strb_q),
        .reg_in_i (reg_in_q),
        .ir_i     (ir_q),
        .il_i     (il_q),
        .shadow_o (shadow)
    );
`else
    assign shadow = '0;
`endif

endmodule

// File: tb/tb_reg_ctrl_seq.sv
// Scoreboard bench for reg_ctrl_seq: per-cycle expected output vectors queued at request time.
module tb_reg_ctrl_seq;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
`ifdef REG_CTRL_SEQ_SHADOW_EN
    localparam bit SH_EN = 1'b1;
`else
    localparam bit SH_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [CW-1:0] req_cnt;
    logic [DW-1:0] req_data;
    logic          req_fill;
    logic          done;
    logic          reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl;
    logic [DW-1:0] reg_in;
    logic          reg_ir, reg_il;
    logic [DW-1:0] shadow;

    int            n_vec = 0;
    int            n_err = 0;
    logic [25:0]   exp_q[$];
    logic [DW-1:0] shadow_m = '0;

    reg_ctrl_seq #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_cnt   (req_cnt),
        .req_data  (req_data),
        .req_fill  (req_fill),
        .done      (done),
        .reg_cl    (reg_cl),
        .reg_ld    (reg_ld),
        .reg_inc   (reg_inc),
        .reg_dec   (reg_dec),
        .reg_sr    (reg_sr),
        .reg_sl    (reg_sl),
        .reg_in    (reg_in),
        .reg_ir    (reg_ir),
        .reg_il    (reg_il),
        .shadow    (shadow)
    );

    always #5 clk = ~clk;

    // Vector layout: {ready, done, cl, ld, inc, dec, sr, sl, ir, il, reg_in}
    function automatic logic [25:0] mk(input bit rdy, input bit dn, input logic [5:0] stb,
                                       input bit ir, input bit il, input logic [DW-1:0] din);
        return {rdy, dn, stb, ir, il, din};
    endfunction

    function automatic logic [25:0] dut_vec();
        return {req_ready, done, reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl,
                reg_ir, reg_il, reg_in};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] sh_step(input logic [DW-1:0] s, input logic [2:0] op,
                                              input logic [DW-1:0] data, input bit fill);
        case (op)
            3'd1:    return '0;
            3'd2:    return data;
            3'd3:    return s + 16'd1;
            3'd4:    return s - 16'd1;
            3'd5:    return {fill, s[DW-1:1]};
            3'd6:    return {s[DW-2:0], fill};
            default: return s;
        endcase
    endfunction

    // Drive one request, queue its expected per-cycle outputs, then drain and compare.
    task automatic run_req(input logic [2:0] op, input logic [CW-1:0] cnt, input logic [DW-1:0] data,
                           input bit fill, input bit hold_valid, input string tag);
        int          n;
        logic [5:0]  stb;
        logic [25:0] e;
        @(negedge clk);
        req_op    = op;
        req_cnt   = cnt;
        req_data  = data;
        req_fill  = fill;
        req_valid = 1'b1;
        n = (op == 3'd1 || op == 3'd2) ? 1 : ((op >= 3'd3 && op <= 3'd6) ? int'(cnt) : 0);
        case (op)
            3'd1:    stb = 6'b100000;
            3'd2:    stb = 6'b010000;
            3'd3:    stb = 6'b001000;
            3'd4:    stb = 6'b000100;
            3'd5:    stb = 6'b000010;
            3'd6:    stb = 6'b000001;
            default: stb = 6'b000000;
        endcase
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(1'b0, 1'b0, stb, (op == 3'd5) && fill, (op == 3'd6) && fill,
                               (op == 3'd2) ? data : 16'h0000));
            shadow_m = sh_step(shadow_m, op, data, fill);
        end
        exp_q.push_back(mk(1'b0, 1'b1, 6'b0, 1'b0, 1'b0, 16'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 16'h0));
        if (hold_valid) exp_q.push_back(mk(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 16'h0));
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk(tag, 32'(dut_vec()), 32'(e));
            if (!hold_valid || e[25]) req_valid = 1'b0;
        end
        chk({tag, "_shadow"}, 32'(shadow), 32'(SH_EN ? shadow_m : 16'h0));
    endtask

    initial begin
        logic [2:0]    rop;
        logic [CW-1:0] rcnt;
        logic [DW-1:0] rdata;
        bit            rfill;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_cnt   = '0;
        req_data  = '0;
        req_fill  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_idle", 32'(dut_vec()), 32'(mk(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 16'h0)));
        chk("reset_shadow", 32'(shadow), 32'h0);

        run_req(3'd2, 4'd0, 16'h1234, 1'b0, 1'b0, "load_1234");
        run_req(3'd2, 4'd9, 16'h0008, 1'b0, 1'b0, "load_0008");
        run_req(3'd5, 4'd3, 16'hAAAA, 1'b1, 1'b0, "shr3_fill1");
        run_req(3'd2, 4'd0, 16'h0001, 1'b0, 1'b0, "load_0001");
        run_req(3'd4, 4'd2, 16'h0000, 1'b0, 1'b0, "dec2_wrap");
        run_req(3'd3, 4'd15, 16'h0000, 1'b0, 1'b0, "inc15_max");
        run_req(3'd3, 4'd0, 16'h5555, 1'b1, 1'b1, "inc_cnt0_hold");
        run_req(3'd7, 4'd5, 16'h5555, 1'b1, 1'b1, "op7_hold");
        run_req(3'd0, 4'd4, 16'h0000, 1'b0, 1'b0, "nop");
        run_req(3'd1, 4'd5, 16'hFFFF, 1'b1, 1'b0, "clr_cnt5");
        run_req(3'd6, 4'd2, 16'h0000, 1'b1, 1'b0, "shl2_fill1");
        run_req(3'd5, 4'd1, 16'h0000, 1'b0, 1'b1, "shr1_hold");

        for (int k = 0; k < 10; k++) begin
            rop   = 3'($urandom_range(0, 7));
            rcnt  = CW'($urandom_range(0, 15));
            rdata = DW'($urandom);
            rfill = 1'($urandom_range(0, 1));
            run_req(rop, rcnt, rdata, rfill, 1'($urandom_range(0, 1)), "rand");
        end

        // SHL cnt=8 interrupted by reset in its 4th strobe cycle.
        @(negedge clk);
        req_op    = 3'd6;
        req_cnt   = 4'd8;
        req_data  = 16'h0;
        req_fill  = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            chk("shl8_pre_rst", 32'(dut_vec()), 32'(mk(1'b0, 1'b0, 6'b000001, 1'b0, 1'b1, 16'h0)));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("shl8_in_rst", 32'(dut_vec()), 32'(mk(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 16'h0)));
        shadow_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle", 32'(dut_vec()), 32'(mk(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 16'h0)));
        end
        chk("post_rst_shadow", 32'(shadow), 32'h0);

        run_req(3'd3, 4'd3, 16'h0000, 1'b0, 1'b0, "inc3_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
